compare: RTL and testbench

- Registered three-operand magnitude comparator.
- Each clock, samples unsigned operands a, b, c and asserts out when they are strictly descending (a > b > c).
- Leaf block used as a qualifying flag by downstream control logic; purely combinational compare core followed by one output register.

---
 rtl/compare_if.sv | 24 ++
 rtl/compare.sv | 33 +++
 tb/tb_compare.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/compare_if.sv
// Operand/result bundle for the registered three-operand comparator.
// The master drives a, b, c and observes out; the slave is the comparator.
interface compare_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out;

    modport master (
        output a,
        output b,
        output c,
        input  out
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output out
    );
endinterface

// File: rtl/compare.sv
// Registered magnitude comparator: out is 1 one clock after a > b > c is sampled.
// Used as a qualifying flag, so the output is a flop and never glitches.
module compare #(
    parameter int WIDTH = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    compare_if.slave  bus
);

    logic gt_ab;
    logic gt_bc;
    logic out_d;
    logic out_q;

    always_comb begin
        gt_ab = (bus.a > bus.b);
        gt_bc = (bus.b > bus.c);
        out_d = gt_ab & gt_bc;
    end

    // Asynchronous clear discards any pending result the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_compare.sv
// Self-checking bench for compare: directed table, exhaustive sweep,
// random stream against a reference model, and timing corner sequences.
module tb_compare;

    localparam int WIDTH = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    compare_if #(.WIDTH(WIDTH)) bus ();

    compare #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   a;
        int   b;
        int   c;
        logic exp;
    } vec_t;

    // Reference: the three values, in order, must form a strictly descending list.
    function automatic logic model(input int a, input int b, input int c);
        int v[3];
        logic ok;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!(v[i] > v[i+1])) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input int a, input int b, input int c);
        bus.a = a[WIDTH-1:0];
        bus.b = b[WIDTH-1:0];
        bus.c = c[WIDTH-1:0];
    endtask

    // Apply one vector on the falling edge, check one rising edge later.
    task automatic apply_check(input string name, input int a, input int b, input int c,
                               input logic expected);
        @(negedge clk);
        drive(a, b, c);
        @(posedge clk);
        #1;
        chk(name, bus.out, expected);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        int   ones;
        logic exp_q[$];
        int   ra, rb, rc;

        checks = 0;
        errors = 0;

        tbl[0] = '{3, 3, 1, 1'b0};
        tbl[1] = '{5, 2, 2, 1'b0};
        tbl[2] = '{0, 0, 0, 1'b0};
        tbl[3] = '{7, 7, 7, 1'b0};
        tbl[4] = '{7, 6, 5, 1'b1};
        tbl[5] = '{2, 1, 0, 1'b1};
        tbl[6] = '{6, 7, 0, 1'b0};
        tbl[7] = '{7, 0, 7, 1'b0};

        // Reset hold with a true-compare input pattern.
        rst_n = 1'b0;
        drive(7, 4, 1);
        #1;
        chk("reset_async_init", bus.out, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("reset_hold", bus.out, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release_first_edge", bus.out, 1'b1);

        // Directed equality and extreme vectors.
        foreach (tbl[i]) begin
            apply_check($sformatf("table_%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp);
        end

        // Exhaustive sweep, c innermost.
        ones = 0;
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                for (int c = 0; c <= MAXV; c++) begin
                    apply_check($sformatf("sweep_%0d_%0d_%0d", a, b, c), a, b, c, model(a, b, c));
                    if (bus.out === 1'b1) ones++;
                end
            end
        end
        checks++;
        if (ones != 56) begin
            errors++;
            $display("FAIL sweep_true_count: got %0d expected 56", ones);
        end

        // Back-to-back random stream, one new vector per edge.
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom_range(0, MAXV);
            rb = $urandom_range(0, MAXV);
            rc = $urandom_range(0, MAXV);
            drive(ra, rb, rc);
            exp_q.push_back(model(ra, rb, rc));
            @(posedge clk);
            #1;
            chk("random_stream", bus.out, exp_q.pop_front());
        end

        // Latency/throughput: (7,6,5) then (1,2,3) on consecutive edges.
        drive(7, 6, 5);
        @(posedge clk);
        #1;
        drive(1, 2, 3);
        #1;
        chk("latency_first", bus.out, 1'b1);
        @(posedge clk);
        #1;
        chk("latency_second", bus.out, 1'b0);
        // Inputs toggle to a true pattern between edges, then back before the edge.
        #1;
        drive(7, 6, 5);
        #2;
        chk("between_edges_no_effect", bus.out, 1'b0);
        drive(1, 2, 3);
        @(posedge clk);
        #1;
        chk("toggle_ignored", bus.out, 1'b0);

        // Async reset mid-stream with out high.
        drive(7, 6, 5);
        @(posedge clk);
        #1;
        chk("pre_async_reset", bus.out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", bus.out, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("async_reset_no_edge_yet", bus.out, 1'b0);
        @(posedge clk);
        #1;
        chk("async_reset_recover", bus.out, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
